// File: rtl/ray_marcher_pkg.sv
// Shared float format, FSM state encoding and the 27-bit float helpers
// (sign[26], exponent[25:18] bias 127, mantissa[17:0]; exponent 0 reads as zero).
package ray_marcher_pkg;

    localparam int FP_W  = 27;
    localparam int EXP_W = 8;
    localparam int MAN_W = 18;

    typedef logic [FP_W-1:0] fp_t;

    localparam fp_t FP_ZERO    = 27'h0000000;
    localparam fp_t FP_ONE     = 27'h1fc0000;
    localparam fp_t FP_NEG_ONE = 27'h5fc0000;

    typedef enum logic [2:0] {
        S_IDLE, S_P_CALC, S_SDF_WAIT, S_CHECK, S_T_ADD, S_DONE
    } state_e;

    // Truncating multiply; underflow flushes to zero, overflow saturates.
    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic [37:0] prod;
        logic [9:0]  e;
        fp_t         r;
        r    = FP_ZERO;
        prod = {19'b0, 1'b1, a[17:0]} * {19'b0, 1'b1, b[17:0]};
        e    = {2'b0, a[25:18]} + {2'b0, b[25:18]} - 10'd127 + {9'b0, prod[37]};
        if (a[25:18] != 8'd0 && b[25:18] != 8'd0) begin
            if (e[9] || e == 10'd0)
                r = FP_ZERO;
            else if (e >= 10'd255)
                r = {a[26] ^ b[26], 8'hfe, 18'h3ffff};
            else
                r = {a[26] ^ b[26], e[7:0], prod[37] ? prod[36:19] : prod[35:18]};
        end
        return r;
    endfunction

    // Truncating add with three guard bits; result takes the sign of the larger magnitude.
    function automatic fp_t fp_add(input fp_t a, input fp_t b);
        fp_t         x, y, r;
        logic [7:0]  ed, e;
        logic [22:0] mx, my, s;
        if (a[25:0] >= b[25:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ed = x[25:18] - y[25:18];
        e  = x[25:18];
        mx = {2'b01, x[17:0], 3'b000};
        my = (ed > 8'd21) ? 23'd0 : ({2'b01, y[17:0], 3'b000} >> ed);
        s  = (x[26] == y[26]) ? mx + my : mx - my;
        if (s[22]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        for (int i = 0; i < 21; i++) begin
            if (!s[21] && s != 23'd0 && e > 8'd1) begin
                s = s << 1;
                e = e - 8'd1;
            end
        end
        if (y[25:18] == 8'd0)
            r = x;
        else if (s == 23'd0)
            r = FP_ZERO;
        else
            r = {x[26], e, s[20:3]};
        return r;
    endfunction

endpackage

// File: rtl/ray_marcher_if.sv
// Ray request, SDF sample/distance and result handshake bundle of the ray marcher.
interface ray_marcher_if;
    import ray_marcher_pkg::*;

    // valid/ready: a transfer happens on a rising clk edge where both valid and ready are high;
    // the sender holds its payload stable and keeps valid high until that edge.
    logic       in_valid;
    logic       in_ready;
    fp_t        org_x, org_y, org_z;
    fp_t        dir_x, dir_y, dir_z;
    fp_t        point_x, point_y, point_z;
    fp_t        distance;
    logic       out_valid;
    logic       out_ready;
    logic       hit;
    fp_t        t_out;
    logic [7:0] iter_out;

    modport master (
        input  in_valid, org_x, org_y, org_z, dir_x, dir_y, dir_z, distance, out_ready,
        output in_ready, point_x, point_y, point_z, out_valid, hit, t_out, iter_out
    );

    modport slave (
        output in_valid, org_x, org_y, org_z, dir_x, dir_y, dir_z, distance, out_ready,
        input  in_ready, point_x, point_y, point_z, out_valid, hit, t_out, iter_out
    );

endinterface

// File: rtl/ray_marcher_vec_fma3.sv
// p = org + t*dir per axis: MUL_LAT product stages, then ADD_LAT-1 sum stages;
// the caller's point register supplies the last stage.
module vec_fma3
    import ray_marcher_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int ADD_LAT = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  fp_t [2:0] i_org,
    input  fp_t [2:0] i_dir,
    input  fp_t       i_t,
    output fp_t [2:0] o_p
);

    fp_t [2:0] r_prod [MUL_LAT];
    fp_t [2:0] w_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < MUL_LAT; s++) r_prod[s] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) r_prod[0][k] <= fp_mul(i_t, i_dir[k]);
            for (int s = 1; s < MUL_LAT; s++) r_prod[s] <= r_prod[s-1];
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 3; k++) w_sum[k] = fp_add(i_org[k], r_prod[MUL_LAT-1][k]);
    end

    generate
        if (ADD_LAT > 1) begin : g_add_pipe
            fp_t [2:0] r_sum [ADD_LAT-1];
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < ADD_LAT-1; s++) r_sum[s] <= '0;
                end else begin
                    r_sum[0] <= w_sum;
                    for (int s = 1; s < ADD_LAT-1; s++) r_sum[s] <= r_sum[s-1];
                end
            end
            assign o_p = r_sum[ADD_LAT-2];
        end else begin : g_add_comb
            assign o_p = w_sum;
        end
    endgenerate

endmodule

// File: rtl/ray_marcher.sv
// Sphere-tracing controller: marches one ray through the SDF until hit, escape or
// iteration cap, then offers hit / t / evaluation count downstream.
module ray_marcher
    import ray_marcher_pkg::*;
#(
    parameter int  SDF_LAT  = 3,
    parameter int  ADD_LAT  = 2,
    parameter int  MUL_LAT  = 1,
    parameter int  MAX_ITER = 64,
    parameter fp_t EPS      = 27'h1e40000,
    parameter fp_t T_MAX    = 27'h20c0000
) (
    input  logic            clk,
    input  logic            rst_n,
    ray_marcher_if.master   bus,
    output state_e          o_dbg_state
);

    localparam int P_WAIT = MUL_LAT + ADD_LAT - 1;

    state_e     r_state;
    fp_t [2:0]  r_org, r_dir, r_point;
    fp_t        r_t, r_d, r_t_out;
    logic [7:0] r_iter, r_cnt, r_iter_out;
    logic       r_in_ready, r_out_valid, r_hit;
    fp_t [2:0]  w_p;
    fp_t        w_t_next;

    vec_fma3 #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_fma (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_org   (r_org),
        .i_dir   (r_dir),
        .i_t     (r_t),
        .o_p     (w_p)
    );

    // t and d are held for the whole T_ADD countdown, so the sum is valid when it expires.
    assign w_t_next = fp_add(r_t, r_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_org       <= '0;
            r_dir       <= '0;
            r_point     <= '0;
            r_t         <= FP_ZERO;
            r_d         <= FP_ZERO;
            r_iter      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_t_out     <= FP_ZERO;
            r_iter_out  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_org      <= {bus.org_z, bus.org_y, bus.org_x};
                    r_dir      <= {bus.dir_z, bus.dir_y, bus.dir_x};
                    r_t        <= FP_ZERO;
                    r_iter     <= '0;
                    r_cnt      <= 8'(P_WAIT);
                    r_in_ready <= 1'b0;
                    r_state    <= S_P_CALC;
                end
                S_P_CALC: if (r_cnt == 8'd0) begin
                    r_point <= w_p;
                    r_iter  <= r_iter + 8'd1;
                    r_cnt   <= 8'(SDF_LAT - 1);
                    r_state <= S_SDF_WAIT;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                S_SDF_WAIT: if (r_cnt == 8'd0) begin
                    r_d     <= bus.distance;
                    r_state <= S_CHECK;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                // Hit is tested before the cap so a hit on the last evaluation still counts.
                S_CHECK: if (r_d[26] || r_d[25:0] < EPS[25:0]) begin
                    r_hit       <= 1'b1;
                    r_t_out     <= r_t;
                    r_iter_out  <= r_iter;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end else if (r_iter == 8'(MAX_ITER)) begin
                    r_hit       <= 1'b0;
                    r_t_out     <= r_t;
                    r_iter_out  <= r_iter;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end else begin
                    r_cnt   <= 8'(ADD_LAT - 1);
                    r_state <= S_T_ADD;
                end
                S_T_ADD: if (r_cnt == 8'd0) begin
                    r_t <= w_t_next;
                    if (w_t_next[25:0] > T_MAX[25:0]) begin
                        r_hit       <= 1'b0;
                        r_t_out     <= w_t_next;
                        r_iter_out  <= r_iter;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt   <= 8'(P_WAIT);
                        r_state <= S_P_CALC;
                    end
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                S_DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.point_x   = r_point[0];
    assign bus.point_y   = r_point[1];
    assign bus.point_z   = r_point[2];
    assign bus.out_valid = r_out_valid;
    assign bus.hit       = r_hit;
    assign bus.t_out     = r_t_out;
    assign bus.iter_out  = r_iter_out;
    assign o_dbg_state   = r_state;

endmodule
